// File: rtl/microwave_ctrl_if.sv
// Front-panel and status bundle for the microwave sequencing controller.
// The panel/bench side is the master (drives buttons, keys and the door
// switch); the controller is the slave (drives time, lamp, magnetron, status).
interface microwave_ctrl_if;
    logic [9:0]  keypad;
    logic        startn;
    logic        stopn;
    logic        clearn;
    logic        door_closed;
    logic [15:0] time_bcd;
    logic        mag_on;
    logic        lamp_on;
    logic        timer_done;
    logic [2:0]  state;

    modport master (
        output keypad, startn, stopn, clearn, door_closed,
        input  time_bcd, mag_on, lamp_on, timer_done, state
    );

    modport slave (
        input  keypad, startn, stopn, clearn, door_closed,
        output time_bcd, mag_on, lamp_on, timer_done, state
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave oven sequencing controller: keypad entry of an MM:SS BCD cook
// time, start/stop/clear/door handling, and a 1 s BCD countdown while cooking.
module microwave_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned PRESC_W       = 7
) (
    input  logic             clk,
    input  logic             resetn,
    microwave_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state_q, state_d;
    logic [15:0]        time_q, time_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               startn_h, stopn_h, clearn_h;
    logic [9:0]         keypad_h;
    logic               mag_q, lamp_q, done_q;

    logic               start_ev, stop_ev, clear_ev, key_ev;
    logic               key_one_hot;
    logic [3:0]         digit;

    // One cycle BCD decrement of MM:SS; seconds wrap 00 -> 59, minutes 10 -> 09.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Edge detection on buttons and keypad; a key counts only as a clean one-hot after all-released.
    always_comb begin
        start_ev    = startn_h & ~bus.startn;
        stop_ev     = stopn_h  & ~bus.stopn;
        clear_ev    = clearn_h & ~bus.clearn;
        key_one_hot = (bus.keypad != '0) && ((bus.keypad & (bus.keypad - 10'd1)) == '0);
        key_ev      = key_one_hot && (keypad_h == '0);
        digit       = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bus.keypad[i]) digit = 4'(i);
        end
    end

    // Next state, time and prescaler; priority door-open > stop > clear > start > key.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        case (state_q)
            IDLE: begin
                if (stop_ev) begin
                    state_d = IDLE;
                end else if (clear_ev) begin
                    time_d = '0;
                end else if (start_ev) begin
                    if (bus.door_closed && time_q != '0) begin
                        state_d = COOK;
                        presc_d = '0;
                    end
                end else if (key_ev) begin
                    time_d = {time_q[11:0], digit};
                end
            end
            COOK: begin
                if (!bus.door_closed || stop_ev) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    time_d  = bcd_dec(time_q);
                    if (time_q == 16'h0001) state_d = DONE;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            PAUSE: begin
                if (stop_ev || clear_ev) begin
                    state_d = IDLE;
                    time_d  = '0;
                    presc_d = '0;
                end else if (start_ev) begin
                    if (bus.door_closed) state_d = COOK;
                end else if (key_ev) begin
                    time_d = {time_q[11:0], digit};
                end
            end
            DONE: begin
                time_d = '0;
                if (!bus.door_closed || stop_ev || clear_ev || start_ev || key_ev) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = '0;
                presc_d = '0;
            end
        endcase
    end

    // State, history and registered outputs; outputs are derived from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            time_q   <= '0;
            presc_q  <= '0;
            startn_h <= 1'b1;
            stopn_h  <= 1'b1;
            clearn_h <= 1'b1;
            keypad_h <= '0;
            mag_q    <= 1'b0;
            lamp_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            startn_h <= bus.startn;
            stopn_h  <= bus.stopn;
            clearn_h <= bus.clearn;
            keypad_h <= bus.keypad;
            mag_q    <= (state_d == COOK);
            lamp_q   <= (state_d == COOK) || !bus.door_closed;
            done_q   <= (state_d == DONE);
        end
    end

    assign bus.time_bcd   = time_q;
    assign bus.mag_on     = mag_q;
    assign bus.lamp_on    = lamp_q;
    assign bus.timer_done = done_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a decimal-arithmetic reference model.
module tb_microwave_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    microwave_ctrl_if bus();

    microwave_ctrl #(.TICKS_PER_SEC(T), .PRESC_W(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time held as a 4-digit decimal number MMSS.
    int         m_state;  // 0 idle, 1 cook, 2 pause, 3 done
    int         m_n;
    int         m_presc;
    bit         m_start_h, m_stop_h, m_clear_h;
    logic [9:0] m_key_h;
    bit         m_mag, m_lamp, m_done;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int secs_to_n(input int s);
        return (s / 60) * 100 + (s % 60);
    endfunction

    task automatic model_edge();
        bit st, sp, cl, ky, open;
        int d, mm, ss;
        if (!resetn) begin
            m_state = 0; m_n = 0; m_presc = 0;
            m_start_h = 1; m_stop_h = 1; m_clear_h = 1; m_key_h = '0;
            m_mag = 0; m_lamp = 0; m_done = 0;
        end else begin
            st   = m_start_h && !bus.startn;
            sp   = m_stop_h  && !bus.stopn;
            cl   = m_clear_h && !bus.clearn;
            ky   = ($countones(bus.keypad) == 1) && (m_key_h == '0);
            open = !bus.door_closed;
            d    = 0;
            for (int i = 0; i < 10; i++) if (bus.keypad[i]) d = i;
            case (m_state)
                0: begin
                    if (sp) ;
                    else if (cl) m_n = 0;
                    else if (st) begin
                        if (!open && m_n != 0) begin m_state = 1; m_presc = 0; end
                    end else if (ky) m_n = (m_n * 10 + d) % 10000;
                end
                1: begin
                    if (open || sp) m_state = 2;
                    else if (m_presc == T - 1) begin
                        m_presc = 0;
                        mm = m_n / 100; ss = m_n % 100;
                        if (ss > 0) ss--; else begin mm--; ss = 59; end
                        m_n = mm * 100 + ss;
                        if (m_n == 0) m_state = 3;
                    end else m_presc++;
                end
                2: begin
                    if (sp || cl) begin m_state = 0; m_n = 0; m_presc = 0; end
                    else if (st) begin if (!open) m_state = 1; end
                    else if (ky) m_n = (m_n * 10 + d) % 10000;
                end
                default: begin
                    m_n = 0;
                    if (open || sp || cl || st || ky) m_state = 0;
                end
            endcase
            m_start_h = bus.startn; m_stop_h = bus.stopn; m_clear_h = bus.clearn;
            m_key_h = bus.keypad;
            m_mag  = (m_state == 1);
            m_lamp = (m_state == 1) || open;
            m_done = (m_state == 3);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int d);
        bus.keypad = 10'(1 << d);
        cyc();
        bus.keypad = '0;
        cyc();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc();
        checks++;
        if ({bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d t=%h mag=%b lamp=%b done=%b want all zero",
                     bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done);
        end
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_entry();
        press_key(1); press_key(3); press_key(0);
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        checks++;
        if ({bus.time_bcd, bus.state, bus.mag_on} !== {16'h0130, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL entry_start: got t=%h st=%0d mag=%b want t=0130 st=1 mag=1",
                     bus.time_bcd, bus.state, bus.mag_on);
        end
        repeat (T) cyc();
        checks++;
        if (bus.time_bcd !== 16'h0129) begin
            errors++;
            $display("FAIL entry_first_tick: got %h want 0129", bus.time_bcd);
        end
        repeat (T * 59) cyc();
        checks++;
        if (bus.time_bcd !== 16'h0030) begin
            errors++;
            $display("FAIL entry_60s: got %h want 0030", bus.time_bcd);
        end
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
        checks++;
        if ({bus.state, bus.mag_on} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL stop_pause: got st=%0d mag=%b want st=2 mag=0", bus.state, bus.mag_on);
        end
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
        checks++;
        if ({bus.state, bus.time_bcd} !== {3'd0, 16'h0000}) begin
            errors++;
            $display("FAIL pause_stop_idle: got st=%0d t=%h want st=0 t=0000", bus.state, bus.time_bcd);
        end
    endtask

    task automatic test_borrow_done();
        press_key(1); press_key(0); press_key(0);
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        checks++;
        if (bus.time_bcd !== 16'h0100) begin
            errors++;
            $display("FAIL borrow_start: got %h want 0100", bus.time_bcd);
        end
        for (int s = 59; s >= 0; s--) begin
            repeat (T) cyc();
            checks++;
            if (bus.time_bcd !== to_bcd(secs_to_n(s))) begin
                errors++;
                $display("FAIL borrow_seq: got %h want %h", bus.time_bcd, to_bcd(secs_to_n(s)));
            end
        end
        checks++;
        if ({bus.state, bus.timer_done, bus.mag_on} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL done_edge: got st=%0d done=%b mag=%b want st=3 done=1 mag=0",
                     bus.state, bus.timer_done, bus.mag_on);
        end
        cyc();
        checks++;
        if ({bus.state, bus.time_bcd, bus.mag_on} !== {3'd3, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL done_hold: got st=%0d t=%h mag=%b want st=3 t=0000 mag=0",
                     bus.state, bus.time_bcd, bus.mag_on);
        end
        bus.clearn = 1'b0; cyc(); bus.clearn = 1'b1;
        checks++;
        if ({bus.state, bus.timer_done} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL done_clear: got st=%0d done=%b want st=0 done=0", bus.state, bus.timer_done);
        end
        cyc();
    endtask

    task automatic test_door_pause();
        press_key(4); press_key(6);
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        repeat (T) cyc();
        repeat (2) cyc();
        bus.door_closed = 1'b0; cyc();
        checks++;
        if ({bus.state, bus.mag_on, bus.lamp_on, bus.time_bcd} !== {3'd2, 1'b0, 1'b1, 16'h0045}) begin
            errors++;
            $display("FAIL door_pause: got st=%0d mag=%b lamp=%b t=%h want st=2 mag=0 lamp=1 t=0045",
                     bus.state, bus.mag_on, bus.lamp_on, bus.time_bcd);
        end
        repeat (5) cyc();
        bus.door_closed = 1'b1; cyc();
        checks++;
        if ({bus.lamp_on, bus.time_bcd} !== {1'b0, 16'h0045}) begin
            errors++;
            $display("FAIL door_close_hold: got lamp=%b t=%h want lamp=0 t=0045", bus.lamp_on, bus.time_bcd);
        end
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        cyc();
        checks++;
        if ({bus.state, bus.time_bcd} !== {3'd1, 16'h0045}) begin
            errors++;
            $display("FAIL resume_early: got st=%0d t=%h want st=1 t=0045", bus.state, bus.time_bcd);
        end
        cyc();
        checks++;
        if (bus.time_bcd !== 16'h0044) begin
            errors++;
            $display("FAIL resume_prescale: got %h want 0044", bus.time_bcd);
        end
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
    endtask

    task automatic test_simultaneous();
        press_key(1); press_key(0);
        bus.startn = 1'b0; bus.stopn = 1'b0; cyc();
        bus.startn = 1'b1; bus.stopn = 1'b1;
        checks++;
        if ({bus.state, bus.time_bcd} !== {3'd0, 16'h0010}) begin
            errors++;
            $display("FAIL start_stop_same: got st=%0d t=%h want st=0 t=0010", bus.state, bus.time_bcd);
        end
        bus.door_closed = 1'b0;
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        checks++;
        if ({bus.state, bus.lamp_on, bus.mag_on} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_door_open: got st=%0d lamp=%b mag=%b want st=0 lamp=1 mag=0",
                     bus.state, bus.lamp_on, bus.mag_on);
        end
        bus.door_closed = 1'b1; cyc();
        bus.clearn = 1'b0; cyc(); bus.clearn = 1'b1;
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        checks++;
        if ({bus.state, bus.time_bcd, bus.mag_on} !== {3'd0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL start_zero_time: got st=%0d t=%h mag=%b want st=0 t=0000 mag=0",
                     bus.state, bus.time_bcd, bus.mag_on);
        end
        cyc();
    endtask

    task automatic test_keypad();
        bus.keypad = 10'b00_0000_0110; cyc(); bus.keypad = '0; cyc();
        checks++;
        if (bus.time_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL key_two_bits: got %h want 0000", bus.time_bcd);
        end
        bus.keypad = 10'(1 << 7); repeat (10) cyc(); bus.keypad = '0; cyc();
        checks++;
        if (bus.time_bcd !== 16'h0007) begin
            errors++;
            $display("FAIL key_held: got %h want 0007", bus.time_bcd);
        end
        bus.clearn = 1'b0; cyc(); bus.clearn = 1'b1;
        for (int d = 1; d <= 5; d++) press_key(d);
        checks++;
        if (bus.time_bcd !== 16'h2345) begin
            errors++;
            $display("FAIL key_five_digits: got %h want 2345", bus.time_bcd);
        end
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        press_key(9);
        checks++;
        if ({bus.state, bus.time_bcd} !== {3'd1, 16'h2345}) begin
            errors++;
            $display("FAIL key_in_cook: got st=%0d t=%h want st=1 t=2345", bus.state, bus.time_bcd);
        end
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
        bus.stopn = 1'b0; cyc(); bus.stopn = 1'b1; cyc();
    endtask

    task automatic test_reset_mid();
        press_key(2); press_key(1);
        bus.startn = 1'b0; cyc(); bus.startn = 1'b1;
        repeat (T) cyc();
        checks++;
        if (bus.time_bcd !== 16'h0020) begin
            errors++;
            $display("FAIL reset_mid_setup: got %h want 0020", bus.time_bcd);
        end
        bus.door_closed = 1'b0;
        resetn = 1'b0; cyc();
        checks++;
        if ({bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid: got st=%0d t=%h mag=%b lamp=%b done=%b want all zero",
                     bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done);
        end
        resetn = 1'b1; cyc();
        checks++;
        if ({bus.state, bus.lamp_on} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_lamp: got st=%0d lamp=%b want st=0 lamp=1", bus.state, bus.lamp_on);
        end
        bus.door_closed = 1'b1; cyc();
    endtask

    task automatic test_random();
        int r, a, b;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) bus.keypad = '0;
            else if (r < 9) bus.keypad = 10'(1 << $urandom_range(0, 9));
            else begin
                a = $urandom_range(0, 9); b = $urandom_range(0, 9);
                bus.keypad = 10'((1 << a) | (1 << b));
            end
            bus.startn = ($urandom_range(0, 7) != 0);
            bus.stopn  = ($urandom_range(0, 29) != 0);
            bus.clearn = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 39) == 0) bus.door_closed = ~bus.door_closed;
            resetn = ($urandom_range(0, 499) != 0);
            cyc();
            checks++;
            if ({bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done} !==
                {3'(m_state), to_bcd(m_n), m_mag, m_lamp, m_done}) begin
                errors++;
                $display("FAIL random_cycle%0d: got st=%0d t=%h mag=%b lamp=%b done=%b want st=%0d t=%h mag=%b lamp=%b done=%b",
                         n, bus.state, bus.time_bcd, bus.mag_on, bus.lamp_on, bus.timer_done,
                         m_state, to_bcd(m_n), m_mag, m_lamp, m_done);
            end
        end
        resetn = 1'b1;
        bus.keypad = '0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1;
        cyc();
    endtask

    initial begin
        bus.keypad      = '0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;
        test_reset();
        test_entry();
        test_borrow_done();
        test_door_pause();
        test_simultaneous();
        test_keypad();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Central sequencing controller for the microwave oven. Captures one-hot keypad digits into a 4-digit BCD cook time (MM:SS) and interprets the active-low start/stop/clear buttons and the door switch. Runs the cook state machine and counts the time down with a clock-derived 1 s tick. Drives the magnetron enable, cavity lamp and timer_done status consumed by the display and buzzer logic.

Parameters:
TICKS_PER_SEC, 100, clk cycles per 1 s countdown tick (≥2); bench uses 4
PRESC_W, 7, prescaler counter width; must satisfy 2^PRESC_W ≥ TICKS_PER_SEC

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
keypad  input  10  one-hot digit keys, bit i = digit i, active high, level
startn  input  1  start button, active low, pre-synchronised/debounced
stopn  input  1  stop/pause button, active low
clearn  input  1  clear button, active low
door_closed  input  1  1 = door closed
time_bcd  output  16  {min_tens, min_units, sec_tens, sec_units}, BCD
mag_on  output  1  magnetron enable, registered
lamp_on  output  1  cavity lamp, registered
timer_done  output  1  cook complete status, registered
state  output  3  current FSM state code, for debug/display

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, time_bcd=16'h0000, mag_on=0, lamp_on=0, timer_done=0, prescaler=0, button/keypad history regs=released (buttons 1, keypad 0).
- Events: press = history 1 and current 0 for buttons; key press = keypad one-hot (exactly one bit set) and previous keypad sample all-zero. Zero or multiple bits set = no key. Every event is one cycle, acted on in the same cycle it is detected; effects visible next cycle.
- States: IDLE=0, COOK=1, PAUSE=2, DONE=3.
- Digit entry (IDLE and PAUSE only): time_bcd <= {time_bcd[11:0], digit}. Old min_tens is discarded. sec_tens 6..9 is allowed, e.g. 0090 cooks 90 s.
- IDLE: start press with door_closed=1 and time≠0 -> COOK, prescaler=0. Start with time=0 or door open: ignored. Clear press: time=0.
- COOK: mag_on=1; keypad and clear ignored. Prescaler increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and time decrements.
  - BCD decrement: sec_units borrows from sec_tens.
  - Seconds 00 -> 59 with minutes decremented; minutes borrow 10->09.
  - Decrement from 0001 -> 0000 and transition to DONE in the same edge.
- COOK exits:
  - door_closed=0 -> PAUSE, prescaler frozen.
  - Stop press -> PAUSE, prescaler frozen.
  - Door open outranks tick: no decrement that cycle.
- PAUSE: mag_on=0. Start press with door_closed=1 -> COOK, prescaler resumes from frozen value. Stop or clear press -> time=0, prescaler=0, IDLE.
- DONE: timer_done=1, mag_on=0, time=0000. Stop, clear, start, door open or key press -> IDLE, timer_done=0. A key press in DONE is consumed, not entered.
- Simultaneous events, in priority order: door-open > stop > clear > start > key. Start and stop in the same cycle = stop only.
- lamp_on = 1 in COOK or whenever door_closed=0, else 0.
- mag_on registered: never 1 in the cycle after door_closed is sampled low.
- Reset mid-operation: immediately returns all outputs to reset values; no partial completion.
- state output shows the registered state.

Test Plan:
- Entry: keys 1,3,0 then start, door closed, TICKS_PER_SEC=4 -> time_bcd 0130, state COOK, mag_on=1; after 4 cycles time 0129; after 60 s of ticks time 0030.
- Borrow/done: enter 0100, start -> sequence 0100, 0059, ..., 0001, 0000. timer_done=1 and state DONE on the same edge as 0000; mag_on=0 next cycle.
- Door open at time 0045 mid-prescale (count 2) -> PAUSE, mag_on=0, lamp_on=1, time holds 0045. Close door and press start -> decrement after 2 more cycles, not 4.
- Simultaneous: start and stop pressed in same cycle in IDLE with time 0010 -> stays IDLE. Start with door open -> ignored. Start with time 0000 -> ignored.
- Keypad rules: two bits set -> no change. Held single key for 10 cycles -> one digit. Keys pressed during COOK ignored. Five digits 1,2,3,4,5 -> 2345.
- Reset: assert resetn=0 for one cycle during COOK at 0020 -> time 0000, IDLE, mag_on=0, lamp_on reflects door only after reset deasserts.
